// File: rtl/fir_sequencer.sv
// Run-level controller for the FIR core: loads samples from a valid/ready stream,
// commands computation, waits for done, and streams results back out.
`timescale 1ns/1ps

module fir_sequencer #(
   parameter int unsigned N            = 10,
   parameter int unsigned SIGNAL_COUNT = 10,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned TIMEOUT      = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [31:0]       core_addr,
   output logic [DATA_W-1:0] core_x,
   output logic [1:0]        core_op,
   input  logic [DATA_W-1:0] core_y,
   input  logic              core_done,
   output logic              busy,
   output logic              run_done,
   output logic              error
);

   localparam int unsigned IDX_W  = 16;
   localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SIGNAL_COUNT - 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

   localparam logic [1:0] OP_IDLE    = 2'b00;
   localparam logic [1:0] OP_LOAD    = 2'b01;
   localparam logic [1:0] OP_COMPUTE = 2'b10;
   localparam logic [1:0] OP_READ    = 2'b11;

   // N only configures the core; the sequencer has nothing to do for an empty filter
   if (N == 0) begin : g_no_taps
   end

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COMPUTE,
      RD_ADDR,
      RD_CAP,
      RD_OUT
   } state_t;

   state_t              state, state_n;
   logic [IDX_W-1:0]    idx, idx_n;
   logic [TCNT_W-1:0]   tcnt, tcnt_n;
   logic [31:0]         core_addr_n;
   logic [DATA_W-1:0]   core_x_n;
   logic [1:0]          core_op_n;
   logic                in_ready_n;
   logic                out_valid_n;
   logic [DATA_W-1:0]   out_data_n;
   logic                busy_n;
   logic                run_done_n;
   logic                error_n;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         tcnt      <= '0;
         core_addr <= '0;
         core_x    <= '0;
         core_op   <= OP_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         run_done  <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         tcnt      <= tcnt_n;
         core_addr <= core_addr_n;
         core_x    <= core_x_n;
         core_op   <= core_op_n;
         in_ready  <= in_ready_n;
         out_valid <= out_valid_n;
         out_data  <= out_data_n;
         busy      <= busy_n;
         run_done  <= run_done_n;
         error     <= error_n;
      end
   end

   // Next-state and next-output logic; outputs are set on entry to the state that shows them
   always_comb begin
      state_n     = state;
      idx_n       = idx;
      tcnt_n      = tcnt;
      core_addr_n = core_addr;
      core_x_n    = core_x;
      core_op_n   = core_op;
      in_ready_n  = in_ready;
      out_valid_n = out_valid;
      out_data_n  = out_data;
      run_done_n  = 1'b0;
      error_n     = error;

      case (state)
         IDLE: begin
            core_op_n = OP_IDLE;
            if (start) begin
               state_n    = LOAD;
               idx_n      = '0;
               in_ready_n = 1'b1;
               error_n    = 1'b0;
               core_op_n  = OP_LOAD;
            end
         end

         LOAD: begin
            core_op_n = OP_LOAD;
            if (in_valid && in_ready) begin
               core_x_n    = in_data;
               core_addr_n = 32'(idx);
               idx_n       = idx + 1'b1;
               // the final write stays on op 01 for one cycle so the core still captures it
               if (idx == LAST_IDX) begin
                  in_ready_n = 1'b0;
                  state_n    = COMPUTE;
                  tcnt_n     = '0;
               end
            end
         end

         COMPUTE: begin
            core_op_n   = OP_COMPUTE;
            core_addr_n = '0;
            if (core_done) begin
               state_n     = RD_ADDR;
               idx_n       = '0;
               core_op_n   = OP_READ;
               core_addr_n = '0;
            end else if (tcnt == TCNT_LAST) begin
               error_n   = 1'b1;
               state_n   = IDLE;
               core_op_n = OP_IDLE;
            end else begin
               tcnt_n = tcnt + 1'b1;
            end
         end

         RD_ADDR: begin
            state_n = RD_CAP;
         end

         RD_CAP: begin
            out_data_n  = core_y;
            out_valid_n = 1'b1;
            state_n     = RD_OUT;
         end

         RD_OUT: begin
            if (out_ready) begin
               out_valid_n = 1'b0;
               if (idx == LAST_IDX) begin
                  run_done_n  = 1'b1;
                  state_n     = IDLE;
                  core_op_n   = OP_IDLE;
                  core_addr_n = '0;
               end else begin
                  idx_n       = idx + 1'b1;
                  core_addr_n = 32'(idx + 1'b1);
                  core_op_n   = OP_READ;
                  state_n     = RD_ADDR;
               end
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer with a behavioural core (y = 2*x, done 5 cycles after op 10).
`timescale 1ns/1ps

module tb_fir_sequencer;

   localparam int SC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready = 1'b0;
   logic [31:0] core_addr;
   logic [31:0] core_x;
   logic [1:0]  core_op;
   logic [31:0] core_y;
   logic        core_done;
   logic        busy;
   logic        run_done;
   logic        error;

   int n_cmp = 0;
   int n_err = 0;

   // core model and stream monitors
   logic [31:0] mem [16];
   int          dcnt = 0;
   bit          no_done = 1'b0;
   logic [31:0] outs [$];
   int          rd_cnt = 0;
   int          bz_cnt = 0;
   int          ov_cnt = 0;

   fir_sequencer #(
      .N(10), .SIGNAL_COUNT(SC), .DATA_W(32), .TIMEOUT(20)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .core_addr(core_addr), .core_x(core_x), .core_op(core_op),
      .core_y(core_y), .core_done(core_done),
      .busy(busy), .run_done(run_done), .error(error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (core_op == 2'b01) mem[core_addr[3:0]] <= core_x;
      core_y <= mem[core_addr[3:0]] << 1;
      if (core_op == 2'b10) dcnt <= dcnt + 1;
      else dcnt <= 0;
   end

   assign core_done = !no_done && (dcnt >= 5);

   always @(posedge clk) begin
      if (out_valid && out_ready) outs.push_back(out_data);
      if (run_done) rd_cnt <= rd_cnt + 1;
      if (busy) bz_cnt <= bz_cnt + 1;
      if (out_valid) ov_cnt <= ov_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values();
      check("rst_core_op", core_op, 0);
      check("rst_core_addr", core_addr, 0);
      check("rst_core_x", core_x, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_run_done", run_done, 0);
      check("rst_error", error, 0);
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_in_ready", in_ready, 1);
      check("start_core_op", core_op, 1);
   endtask

   task automatic load_samples(input int base, input int cnt, input bit gap);
      for (int k = 0; k < cnt; k++) begin
         in_valid = 1'b1;
         in_data  = 32'(base + k);
         step();
         in_valid = 1'b0;
         check("load_x", core_x, base + k);
         check("load_addr", core_addr, k);
         check("load_op", core_op, 1);
         check("load_in_ready", in_ready, (k == SC - 1) ? 1'b0 : 1'b1);
         if (gap && k < cnt - 1) begin
            for (int g = 0; g < 2; g++) begin
               step();
               check("gap_op", core_op, 1);
               check("gap_addr", core_addr, k);
            end
         end
      end
   endtask

   task automatic wait_outputs(input int base, input bit bp, input bit pulse);
      int  n0;
      int  rd0;
      int  held;
      bit  got_done;
      bit  fin;
      bit  pulsed;
      n0 = outs.size();
      rd0 = rd_cnt;
      held = 0;
      got_done = 1'b0;
      fin = 1'b0;
      pulsed = 1'b0;
      if (pulse) start = 1'b1;
      step();
      start = 1'b0;
      check("compute_op", core_op, 2);
      check("compute_addr", core_addr, 0);
      for (int c = 0; c < 50 && !got_done; c++) begin
         if (core_done) got_done = 1'b1;
         else step();
      end
      check("done_seen", got_done, 1);
      step();
      check("read_op", core_op, 3);
      check("read_addr0", core_addr, 0);
      step();
      step();
      check("first_out_valid", out_valid, 1);
      check("first_out_data", out_data, 2 * base);
      for (int c = 0; c < 200 && !fin; c++) begin
         out_ready = 1'b1;
         if (bp && out_valid && (outs.size() - n0 == 3) && held < 4) begin
            out_ready = 1'b0;
            held++;
            check("bp_hold_data", out_data, 2 * (base + 3));
            check("bp_hold_valid", out_valid, 1);
         end
         if (pulse && out_valid && (outs.size() - n0 == 5) && !pulsed) begin
            start = 1'b1;
            pulsed = 1'b1;
         end
         step();
         start = 1'b0;
         if (run_done) fin = 1'b1;
      end
      out_ready = 1'b0;
      check("run_done_seen", fin, 1);
      check("end_busy", busy, 0);
      check("end_core_op", core_op, 0);
      check("end_core_addr", core_addr, 0);
      if (bp) check("bp_cycles", held, 4);
      check("out_count", outs.size() - n0, SC);
      for (int k = 0; k < SC && (n0 + k) < outs.size(); k++)
         check("out_value", outs[n0 + k], 2 * (base + k));
      for (int k = 0; k < SC; k++)
         check("core_mem", mem[k], base + k);
      step();
      check("run_done_once", rd_cnt - rd0, 1);
      check("run_done_pulse", run_done, 0);
      step();
      check("idle_after_run", busy, 0);
   endtask

   initial begin
      int bz0;
      int ov0;
      step();
      step();
      check_reset_values();
      reset = 1'b0;
      step();

      // nominal run
      bz0 = bz_cnt;
      do_start();
      load_samples(0, SC, 1'b0);
      wait_outputs(0, 1'b0, 1'b0);
      check("busy_cycles", bz_cnt - bz0, 47);

      // input gaps with start pulses in COMPUTE and RD_OUT
      do_start();
      load_samples(100, SC, 1'b1);
      wait_outputs(100, 1'b0, 1'b1);

      // output backpressure on result 3
      do_start();
      load_samples(0, SC, 1'b0);
      wait_outputs(0, 1'b1, 1'b0);

      // compute timeout
      ov0 = ov_cnt;
      no_done = 1'b1;
      do_start();
      load_samples(50, SC, 1'b0);
      for (int i = 0; i < 19; i++) step();
      check("to_error_early", error, 0);
      check("to_busy_early", busy, 1);
      step();
      check("to_error", error, 1);
      check("to_busy", busy, 0);
      check("to_core_op", core_op, 0);
      step();
      check("to_no_out_valid", ov_cnt - ov0, 0);
      check("to_error_sticky", error, 1);
      no_done = 1'b0;
      do_start();
      check("start_clears_error", error, 0);
      load_samples(200, SC, 1'b0);
      wait_outputs(200, 1'b0, 1'b0);

      // reset mid-load
      do_start();
      load_samples(300, 4, 1'b0);
      reset = 1'b1;
      step();
      check_reset_values();
      reset = 1'b0;
      step();
      do_start();
      load_samples(400, SC, 1'b0);
      wait_outputs(400, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
